vending_credit_fsm: RTL and testbench
=====================================

Name: vending_credit_fsm

Overview:
Parametrised successor to the fixed-price coin vending FSM. Accumulates coin credit in kurus against a configurable price and emits a one-cycle product pulse once the price is reached. Returns change or refunds one 5-kurus coin at a time through a valid/ready handshake to the coin hopper. Supports a customer cancel, and rejects illegal or ill-timed coin events.

Parameters:
PRICE, 25, product price in kurus; must be a nonzero multiple of 5.
CREDIT_W, 6, credit register width; must satisfy 2^CREDIT_W > PRICE+20.
CNT_W, 16, vend counter width; used only with VEND_COUNT_EN.

Ports:
clock  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-high reset
fiveKurus  input  1  5-kurus coin accepted this cycle, 1-cycle pulse
tenKurus  input  1  10-kurus coin accepted this cycle, 1-cycle pulse
twentyFiveKurus  input  1  25-kurus coin accepted this cycle, 1-cycle pulse
cancel  input  1  refund request, 1-cycle pulse
theProduct  output  1  dispense pulse, exactly 1 cycle per sale
change_valid  output  1  hopper request: eject one 5-kurus coin
change_ready  input  1  hopper has ejected the coin; transfer completes when valid&ready
credit  output  CREDIT_W  current registered credit in kurus
coin_reject  output  1  1-cycle pulse: the previous cycle's coin event was refused (coin returned mechanically)
busy  output  1  high in VEND or RETURN
vend_count  output  CNT_W  present only with VEND_COUNT_EN

Behaviour:
- Reset, synchronous on clock edge with reset=1:
  - state=IDLE, credit=0.
  - theProduct, change_valid, coin_reject=0; vend_count=0.
  - Reset mid-operation abandons the sale; pending change is forfeited.
- States: IDLE (credit==0), COLLECT (0<credit<PRICE), VEND, RETURN.
- Coin event: exactly one coin input high. Value v = 5, 10 or 25.
- Illegal event: two or more coin inputs high in the same cycle. It is ignored, credit is unchanged, and coin_reject=1 the next cycle.
- IDLE/COLLECT, legal coin without cancel:
  - credit <= credit+v at the next edge.
  - If credit+v >= PRICE, next state is VEND; otherwise COLLECT.
- Cancel in COLLECT:
  - Next state is RETURN; credit is unchanged.
  - A coin in the same cycle is rejected (cancel wins).
  - Cancel in IDLE is ignored.
- VEND (exactly one cycle):
  - theProduct=1.
  - At the next edge credit <= credit-PRICE.
  - Next state is RETURN if the remainder is >0, else IDLE.
  - vend_count increments.
- RETURN:
  - change_valid=1 while credit>0.
  - Each cycle with change_valid&change_ready: credit <= credit-5.
  - When the last transfer makes credit 0, next state is IDLE and change_valid drops in the same edge.
  - change_valid is held until ready; it is never withdrawn early.
  - cancel is ignored.
- Any coin event in VEND or RETURN is rejected: coin_reject pulses next cycle, credit is unchanged.
- Latency:
  - Coin sampled at edge N; credit is visible after N.
  - If the price is reached, theProduct is high in the cycle after edge N, and the remainder is visible one edge later.
- Outputs theProduct, change_valid, busy and credit are decoded from registered state and credit only (Moore style, no combinational input-to-output path). coin_reject is registered.
- Arithmetic is unsigned. Maximum credit is PRICE+20, so no overflow is possible given the CREDIT_W rule.
- No default-case latch: unreachable state encodings go to IDLE with credit cleared.

Optional Feature:
VEND_COUNT_EN.
- Defined: adds output vend_count[CNT_W]. It is cleared by reset, increments once per VEND cycle, and wraps modulo 2^CNT_W.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- PRICE=25, one 25-kurus coin in IDLE:
  - credit=25.
  - theProduct=1 for one cycle.
  - credit=0, back to IDLE.
  - change_valid never asserts.
- 10 then 10 then 10, change_ready tied 1:
  - credit goes 10, 20, 30, then VEND pulse.
  - credit=5, one change transfer, credit=0, IDLE.
- 5 then cancel, change_ready held 0 for 4 cycles then 1:
  - RETURN with change_valid high for 5 cycles.
  - Exactly one transfer, credit goes 5 to 0, IDLE, no theProduct.
- fiveKurus and tenKurus high in the same cycle in IDLE:
  - credit stays 0, coin_reject=1 next cycle, state IDLE.
- 20 credit, then 25 inserted (credit 45), then a 10 coin during RETURN:
  - VEND, then RETURN with 4 transfers (20 to 0).
  - The 10 coin is rejected.
- 10 inserted, reset asserted one cycle, then 25; VEND_COUNT_EN defined:
  - credit=0 after reset.
  - A single vend, vend_count=1.

Source files
------------

// File: rtl/vending_credit_fsm.sv
// rtl/vending_credit_fsm.sv - coin credit vending FSM with handshaked change return (optional VEND_COUNT_EN vend counter)
module vending_credit_fsm #(
    parameter int PRICE    = 25,
    parameter int CREDIT_W = 6,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                fiveKurus,
    input  logic                tenKurus,
    input  logic                twentyFiveKurus,
    input  logic                cancel,
    output logic                theProduct,
    output logic                change_valid,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                busy
`ifdef VEND_COUNT_EN
    ,
    output logic [CNT_W-1:0]    vend_count
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        RETURN  = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] COIN5   = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] COIN10  = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] COIN25  = CREDIT_W'(25);

    state_t              state;
    state_t              stateNext;
    logic [CREDIT_W-1:0] creditReg;
    logic [CREDIT_W-1:0] creditNext;
    logic                rejectReg;
    logic                rejectNext;

    logic [1:0]          coinCount;
    logic                anyCoin;
    logic                legalCoin;
    logic                illegalCoin;
    logic [CREDIT_W-1:0] coinValue;
    logic [CREDIT_W-1:0] creditSum;

    // Classify this cycle's coin inputs and pick the value of a single legal coin
    always_comb begin
        coinCount   = {1'b0, fiveKurus} + {1'b0, tenKurus} + {1'b0, twentyFiveKurus};
        anyCoin     = fiveKurus | tenKurus | twentyFiveKurus;
        legalCoin   = (coinCount == 2'd1);
        illegalCoin = (coinCount >= 2'd2);
        coinValue   = '0;
        if (fiveKurus) begin
            coinValue = COIN5;
        end else if (tenKurus) begin
            coinValue = COIN10;
        end else if (twentyFiveKurus) begin
            coinValue = COIN25;
        end
        creditSum = creditReg + coinValue;
    end

    // Next state, next credit and next reject flag
    always_comb begin
        stateNext  = state;
        creditNext = creditReg;
        rejectNext = 1'b0;
        case (state)
            IDLE, COLLECT: begin
                if (cancel && (state == COLLECT)) begin
                    // Cancel wins over any coin arriving in the same cycle
                    stateNext  = RETURN;
                    rejectNext = anyCoin;
                end else if (illegalCoin) begin
                    rejectNext = 1'b1;
                end else if (legalCoin) begin
                    creditNext = creditSum;
                    stateNext  = (creditSum >= PRICE_C) ? VEND : COLLECT;
                end
            end
            VEND: begin
                rejectNext = anyCoin;
                creditNext = creditReg - PRICE_C;
                stateNext  = (creditReg == PRICE_C) ? IDLE : RETURN;
            end
            RETURN: begin
                rejectNext = anyCoin;
                if (creditReg == '0) begin
                    stateNext = IDLE;
                end else if (change_ready) begin
                    creditNext = creditReg - COIN5;
                    if (creditReg == COIN5) begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext  = IDLE;
                creditNext = '0;
            end
        endcase
    end

    // State, credit and reject registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            creditReg <= '0;
            rejectReg <= 1'b0;
        end else begin
            state     <= stateNext;
            creditReg <= creditNext;
            rejectReg <= rejectNext;
        end
    end

`ifdef VEND_COUNT_EN
    logic [CNT_W-1:0] vendCount;

    // Count completed VEND cycles, wrapping naturally
    always_ff @(posedge clock) begin
        if (reset) begin
            vendCount <= '0;
        end else if (state == VEND) begin
            vendCount <= vendCount + 1'b1;
        end
    end

    assign vend_count = vendCount;
`endif

    // Moore outputs decoded from registered state and credit
    always_comb begin
        theProduct   = (state == VEND);
        change_valid = (state == RETURN) && (creditReg != '0);
        busy         = (state == VEND) || (state == RETURN);
        credit       = creditReg;
        coin_reject  = rejectReg;
    end

endmodule

// File: tb/tb_vending_credit_fsm.sv
// tb/tb_vending_credit_fsm.sv - directed scoreboard bench for vending_credit_fsm
module tb_vending_credit_fsm;

    logic       clock;
    logic       reset;
    logic       fiveKurus;
    logic       tenKurus;
    logic       twentyFiveKurus;
    logic       cancel;
    logic       theProduct;
    logic       change_valid;
    logic       change_ready;
    logic [5:0] credit;
    logic       coin_reject;
    logic       busy;
`ifdef VEND_COUNT_EN
    logic [15:0] vend_count;
`endif

    typedef struct {
        string tag;
        int    cr;
        int    prod;
        int    cv;
        int    rej;
        int    bsy;
    } exp_t;

    exp_t expQ[$];
    int   testCount;
    int   failCount;

    vending_credit_fsm #(.PRICE(25), .CREDIT_W(6), .CNT_W(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .fiveKurus       (fiveKurus),
        .tenKurus        (tenKurus),
        .twentyFiveKurus (twentyFiveKurus),
        .cancel          (cancel),
        .theProduct      (theProduct),
        .change_valid    (change_valid),
        .change_ready    (change_ready),
        .credit          (credit),
        .coin_reject     (coin_reject),
        .busy            (busy)
`ifdef VEND_COUNT_EN
        ,
        .vend_count      (vend_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input int obs, input int expv);
        testCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic expectNext(input string tag, input int cr, input int prod,
                              input int cv, input int rej, input int bsy);
        exp_t e;
        e.tag = tag; e.cr = cr; e.prod = prod; e.cv = cv; e.rej = rej; e.bsy = bsy;
        expQ.push_back(e);
    endtask

    // Apply one cycle of inputs, then compare the post-edge outputs with the next expectation
    task automatic tick(input logic f, input logic t, input logic q, input logic c);
        exp_t e;
        fiveKurus = f; tenKurus = t; twentyFiveKurus = q; cancel = c;
        @(posedge clock);
        #1;
        fiveKurus = 1'b0; tenKurus = 1'b0; twentyFiveKurus = 1'b0; cancel = 1'b0;
        testCount++;
        assert (expQ.size() > 0) else begin
            failCount++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal({e.tag, ".credit"},       int'(credit),       e.cr);
            checkVal({e.tag, ".theProduct"},   int'(theProduct),   e.prod);
            checkVal({e.tag, ".change_valid"}, int'(change_valid), e.cv);
            checkVal({e.tag, ".coin_reject"},  int'(coin_reject),  e.rej);
            checkVal({e.tag, ".busy"},         int'(busy),         e.bsy);
        end
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        reset = 1'b1;
        fiveKurus = 1'b0; tenKurus = 1'b0; twentyFiveKurus = 1'b0; cancel = 1'b0;
        change_ready = 1'b0;

        // Reset state
        expectNext("reset", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);
`ifdef VEND_COUNT_EN
        checkVal("reset.vend_count", int'(vend_count), 0);
`endif
        reset = 1'b0;

        // Exact price with a single 25 coin
        expectNext("q25.vend", 25, 1, 0, 0, 1);
        tick(0, 0, 1, 0);
        expectNext("q25.idle", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);
        expectNext("q25.stay", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Three tens, one 5 change with ready tied high
        change_ready = 1'b1;
        expectNext("t10.c10", 10, 0, 0, 0, 0);
        tick(0, 1, 0, 0);
        expectNext("t10.c20", 20, 0, 0, 0, 0);
        tick(0, 1, 0, 0);
        expectNext("t10.vend", 30, 1, 0, 0, 1);
        tick(0, 1, 0, 0);
        expectNext("t10.ret", 5, 0, 1, 0, 1);
        tick(0, 0, 0, 0);
        expectNext("t10.idle", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Five then cancel, hopper stalls four cycles
        change_ready = 1'b0;
        expectNext("cxl.c5", 5, 0, 0, 0, 0);
        tick(1, 0, 0, 0);
        expectNext("cxl.ret", 5, 0, 1, 0, 1);
        tick(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            expectNext("cxl.hold", 5, 0, 1, 0, 1);
            tick(0, 0, 0, 1);
        end
        change_ready = 1'b1;
        expectNext("cxl.done", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Cancel in IDLE is ignored
        expectNext("idle_cancel", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1);

        // Two coins at once in IDLE
        expectNext("illegal.rej", 0, 0, 0, 1, 0);
        tick(1, 1, 0, 0);
        expectNext("illegal.after", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Cancel with a coin in COLLECT: cancel wins, coin refused
        change_ready = 1'b0;
        expectNext("cxlcoin.c5", 5, 0, 0, 0, 0);
        tick(1, 0, 0, 0);
        expectNext("cxlcoin.ret", 5, 0, 1, 1, 1);
        tick(0, 1, 0, 1);
        change_ready = 1'b1;
        expectNext("cxlcoin.done", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Maximum credit 45, then a coin during RETURN
        change_ready = 1'b0;
        expectNext("big.c10", 10, 0, 0, 0, 0);
        tick(0, 1, 0, 0);
        expectNext("big.c20", 20, 0, 0, 0, 0);
        tick(0, 1, 0, 0);
        expectNext("big.vend", 45, 1, 0, 0, 1);
        tick(0, 0, 1, 0);
        expectNext("big.ret", 20, 0, 1, 0, 1);
        tick(0, 0, 0, 0);
        expectNext("big.coinrej", 20, 0, 1, 1, 1);
        tick(0, 1, 0, 0);
        change_ready = 1'b1;
        expectNext("big.r15", 15, 0, 1, 0, 1);
        tick(0, 0, 0, 0);
        expectNext("big.r10", 10, 0, 1, 0, 1);
        tick(0, 0, 0, 0);
        expectNext("big.r5", 5, 0, 1, 0, 1);
        tick(0, 0, 0, 0);
        expectNext("big.r0", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);

        // Reset mid-collection abandons credit, then a single vend
        expectNext("rst.c10", 10, 0, 0, 0, 0);
        tick(0, 1, 0, 0);
        reset = 1'b1;
        expectNext("rst.clear", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);
`ifdef VEND_COUNT_EN
        checkVal("rst.vend_count0", int'(vend_count), 0);
`endif
        reset = 1'b0;
        expectNext("rst.vend", 25, 1, 0, 0, 1);
        tick(0, 0, 1, 0);
        expectNext("rst.idle", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0);
`ifdef VEND_COUNT_EN
        checkVal("rst.vend_count1", int'(vend_count), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
